// File: rtl/rvfi_regfile_check.sv
// Shadows NTRACK architectural registers and checks every retired rs1/rs2 read against them.
// Optional x0 policing (kind-2 errors, formal assert) is enabled by RVFI_REGFILE_CHECK_X0_EN.
module rvfi_regfile_check #(
  parameter int XLEN      = 32,
  parameter int NRET      = 1,
  parameter int NTRACK    = 4,
  parameter int ZERO_INIT = 0,
  localparam int CW       = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NTRACK*5-1:0]    track_idx,
  input  logic [NRET-1:0]        rvfi_valid,
  input  logic [NRET*5-1:0]      rvfi_rs1,
  input  logic [NRET*5-1:0]      rvfi_rs2,
  input  logic [NRET*5-1:0]      rvfi_rd,
  input  logic [NRET*XLEN-1:0]   rvfi_pre_rs1,
  input  logic [NRET*XLEN-1:0]   rvfi_pre_rs2,
  input  logic [NRET*XLEN-1:0]   rvfi_post_rd,
  output logic                   err_pulse,
  output logic                   err_sticky,
  output logic [CW-1:0]          err_chan,
  output logic [4:0]             err_reg,
  output logic [1:0]             err_kind,
  output logic [XLEN-1:0]        err_expected,
  output logic [XLEN-1:0]        err_actual,
  output logic [31:0]            check_count
);

  localparam logic [1:0] KIND_RS1 = 2'd0;
  localparam logic [1:0] KIND_RS2 = 2'd1;
  localparam logic [1:0] KIND_X0  = 2'd2;

  logic [4:0]        idx_q    [NTRACK];
  logic [XLEN-1:0]   shadow_q [NTRACK];
  logic [NTRACK-1:0] valid_q;

  // Working copies updated channel by channel, so a write on channel i forwards to channel j>i.
  logic [XLEN-1:0]   shadow_n [NTRACK];
  logic [NTRACK-1:0] valid_n;

  logic              found;
  logic [CW-1:0]     f_chan;
  logic [4:0]        f_reg;
  logic [1:0]        f_kind;
  logic [XLEN-1:0]   f_exp;
  logic [XLEN-1:0]   f_act;
  logic [31:0]       incr;
  logic [32:0]       count_sum;

  logic [4:0]        c_rs1;
  logic [4:0]        c_rs2;
  logic [4:0]        c_rd;
  logic [XLEN-1:0]   c_pre1;
  logic [XLEN-1:0]   c_pre2;
  logic [XLEN-1:0]   c_post;

  always_comb begin
    shadow_n = shadow_q;
    valid_n  = valid_q;
    found    = 1'b0;
    f_chan   = '0;
    f_reg    = '0;
    f_kind   = '0;
    f_exp    = '0;
    f_act    = '0;
    incr     = '0;
    c_rs1    = '0;
    c_rs2    = '0;
    c_rd     = '0;
    c_pre1   = '0;
    c_pre2   = '0;
    c_post   = '0;

`ifdef RVFI_REGFILE_CHECK_X0_EN
    // Entries shadowing x0 are hardwired: always valid, always zero.
    for (int e = 0; e < NTRACK; e++) begin
      if (idx_q[e] == 5'd0) begin
        valid_n[e]  = 1'b1;
        shadow_n[e] = '0;
      end
    end
`endif

    for (int c = 0; c < NRET; c++) begin
      if (rvfi_valid[c]) begin
        c_rs1  = rvfi_rs1[c*5 +: 5];
        c_rs2  = rvfi_rs2[c*5 +: 5];
        c_rd   = rvfi_rd[c*5 +: 5];
        c_pre1 = rvfi_pre_rs1[c*XLEN +: XLEN];
        c_pre2 = rvfi_pre_rs2[c*XLEN +: XLEN];
        c_post = rvfi_post_rd[c*XLEN +: XLEN];

        // Loop order encodes error priority: rs1 over rs2 over x0, lowest entry first.
        for (int e = 0; e < NTRACK; e++) begin
          if (valid_n[e] && c_rs1 == idx_q[e]) begin
            incr = incr + 32'd1;
            if (!found && c_pre1 != shadow_n[e]) begin
              found  = 1'b1;
              f_chan = CW'(c);
              f_reg  = c_rs1;
              f_kind = KIND_RS1;
              f_exp  = shadow_n[e];
              f_act  = c_pre1;
            end
          end
        end

        for (int e = 0; e < NTRACK; e++) begin
          if (valid_n[e] && c_rs2 == idx_q[e]) begin
            incr = incr + 32'd1;
            if (!found && c_pre2 != shadow_n[e]) begin
              found  = 1'b1;
              f_chan = CW'(c);
              f_reg  = c_rs2;
              f_kind = KIND_RS2;
              f_exp  = shadow_n[e];
              f_act  = c_pre2;
            end
          end
        end

`ifdef RVFI_REGFILE_CHECK_X0_EN
        if (!found && c_rd == 5'd0 && c_post != '0) begin
          found  = 1'b1;
          f_chan = CW'(c);
          f_reg  = 5'd0;
          f_kind = KIND_X0;
          f_exp  = '0;
          f_act  = c_post;
        end
`endif

        // Writes come after this channel's reads so its own rd is invisible to its own sources.
        for (int e = 0; e < NTRACK; e++) begin
`ifdef RVFI_REGFILE_CHECK_X0_EN
          if (c_rd == idx_q[e] && idx_q[e] != 5'd0) begin
`else
          if (c_rd == idx_q[e]) begin
`endif
            shadow_n[e] = c_post;
            valid_n[e]  = 1'b1;
          end
        end
      end
    end

    count_sum = {1'b0, check_count} + {1'b0, incr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < NTRACK; e++) begin
        idx_q[e]    <= track_idx[e*5 +: 5];
        shadow_q[e] <= '0;
      end
      valid_q      <= (ZERO_INIT != 0) ? '1 : '0;
      err_pulse    <= 1'b0;
      err_sticky   <= 1'b0;
      err_chan     <= '0;
      err_reg      <= '0;
      err_kind     <= '0;
      err_expected <= '0;
      err_actual   <= '0;
      check_count  <= '0;
    end else begin
      shadow_q  <= shadow_n;
      valid_q   <= valid_n;
      err_pulse <= found;
      if (found) begin
        err_sticky   <= 1'b1;
        err_chan     <= f_chan;
        err_reg      <= f_reg;
        err_kind     <= f_kind;
        err_expected <= f_exp;
        err_actual   <= f_act;
      end
      check_count <= count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
    end
  end

`ifdef RVFI_REGFILE_CHECK_X0_EN
`ifdef FORMAL
  always @(posedge clk) begin
    if (!reset) assert (!err_pulse);
  end
`endif
`endif

endmodule

// File: tb/tb_rvfi_regfile_check.sv
// Directed bench: a single-channel checker (idx 5,6,7,8) and a two-channel ZERO_INIT checker (idx 7,0,9,10).
module tb_rvfi_regfile_check;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // single-channel instance
  logic [19:0] track1;
  logic [0:0]  v1;
  logic [4:0]  rs1_1, rs2_1, rd_1;
  logic [31:0] pre1_1, pre2_1, post_1;
  logic        pulse1, sticky1;
  logic [0:0]  chan1;
  logic [4:0]  reg1;
  logic [1:0]  kind1;
  logic [31:0] exp1, act1, cnt1;

  // two-channel instance
  logic [19:0] track2;
  logic [1:0]  v2;
  logic [9:0]  rs1_2, rs2_2, rd_2;
  logic [63:0] pre1_2, pre2_2, post_2;
  logic        pulse2, sticky2;
  logic [0:0]  chan2;
  logic [4:0]  reg2;
  logic [1:0]  kind2;
  logic [31:0] exp2, act2, cnt2;

  rvfi_regfile_check #(.XLEN(32), .NRET(1), .NTRACK(4), .ZERO_INIT(0)) u_dut1 (
    .clk(clk), .reset(reset), .track_idx(track1), .rvfi_valid(v1),
    .rvfi_rs1(rs1_1), .rvfi_rs2(rs2_1), .rvfi_rd(rd_1),
    .rvfi_pre_rs1(pre1_1), .rvfi_pre_rs2(pre2_1), .rvfi_post_rd(post_1),
    .err_pulse(pulse1), .err_sticky(sticky1), .err_chan(chan1), .err_reg(reg1),
    .err_kind(kind1), .err_expected(exp1), .err_actual(act1), .check_count(cnt1)
  );

  rvfi_regfile_check #(.XLEN(32), .NRET(2), .NTRACK(4), .ZERO_INIT(1)) u_dut2 (
    .clk(clk), .reset(reset), .track_idx(track2), .rvfi_valid(v2),
    .rvfi_rs1(rs1_2), .rvfi_rs2(rs2_2), .rvfi_rd(rd_2),
    .rvfi_pre_rs1(pre1_2), .rvfi_pre_rs2(pre2_2), .rvfi_post_rd(post_2),
    .err_pulse(pulse2), .err_sticky(sticky2), .err_chan(chan2), .err_reg(reg2),
    .err_kind(kind2), .err_expected(exp2), .err_actual(act2), .check_count(cnt2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set1(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] po);
    v1 = 1'b1; rs1_1 = rs1; rs2_1 = rs2; rd_1 = rd;
    pre1_1 = p1; pre2_1 = p2; post_1 = po;
  endtask

  task automatic set2(input int ch, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] po);
    v2[ch] = 1'b1;
    rs1_2[ch*5 +: 5] = rs1; rs2_2[ch*5 +: 5] = rs2; rd_2[ch*5 +: 5] = rd;
    pre1_2[ch*32 +: 32] = p1; pre2_2[ch*32 +: 32] = p2; post_2[ch*32 +: 32] = po;
  endtask

  // One clock: inputs set at a negedge are sampled at the posedge, results read at the next negedge.
  task automatic step();
    @(negedge clk);
    v1 = '0;
    v2 = '0;
  endtask

  initial begin
    reset = 1'b1;
    track1 = {5'd8, 5'd7, 5'd6, 5'd5};
    track2 = {5'd10, 5'd9, 5'd0, 5'd7};
    v1 = '0; rs1_1 = '0; rs2_1 = '0; rd_1 = '0; pre1_1 = '0; pre2_1 = '0; post_1 = '0;
    v2 = '0; rs1_2 = '0; rs2_2 = '0; rd_2 = '0; pre1_2 = '0; pre2_2 = '0; post_2 = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_pulse", pulse1, 0);
    check("rst_sticky", sticky1, 0);
    check("rst_count", cnt1, 0);
    check("rst_expected", exp1, 0);

    // single channel: write x5 then read it back correctly
    set1(5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'hDEADBEEF); step();
    check("wr_count", cnt1, 0);
    set1(5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0); step();
    check("rd_ok_pulse", pulse1, 0);
    check("rd_ok_count", cnt1, 1);

    // x6 never written and ZERO_INIT=0: no comparison
    set1(5'd6, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0); step();
    check("unwritten_pulse", pulse1, 0);
    check("unwritten_count", cnt1, 1);

    // rs2 mismatch on x5
    set1(5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEE0, 32'h0); step();
    check("rs2_pulse", pulse1, 1);
    check("rs2_kind", kind1, 1);
    check("rs2_reg", reg1, 5);
    check("rs2_expected", exp1, 32'hDEADBEEF);
    check("rs2_actual", act1, 32'hDEADBEE0);
    check("rs2_sticky", sticky1, 1);
    check("rs2_count", cnt1, 2);

    step();
    check("hold_pulse", pulse1, 0);
    check("hold_sticky", sticky1, 1);
    check("hold_kind", kind1, 1);
    check("hold_expected", exp1, 32'hDEADBEEF);

    // both sources mismatch: rs1 wins
    set1(5'd5, 5'd5, 5'd0, 32'h1, 32'h2, 32'h0); step();
    check("prio_kind", kind1, 0);
    check("prio_actual", act1, 32'h1);
    check("prio_count", cnt1, 4);

    // two channels, ZERO_INIT=1: unwritten x9 reads as 0
    set2(0, 5'd9, 5'd3, 5'd3, 32'h1234, 32'h0, 32'h0); step();
    check("zi_pulse", pulse2, 1);
    check("zi_kind", kind2, 0);
    check("zi_reg", reg2, 9);
    check("zi_expected", exp2, 0);
    check("zi_actual", act2, 32'h1234);
    check("zi_count", cnt2, 1);

    // ch0 writes x7, ch1 reads it in the same cycle
    set2(0, 5'd3, 5'd3, 5'd7, 32'h0, 32'h0, 32'h11);
    set2(1, 5'd7, 5'd3, 5'd3, 32'h11, 32'h0, 32'h0); step();
    check("fwd_pulse", pulse2, 0);
    check("fwd_count", cnt2, 2);

    // both channels write x7: ch1 value survives
    set2(0, 5'd3, 5'd3, 5'd7, 32'h0, 32'h0, 32'h22);
    set2(1, 5'd3, 5'd3, 5'd7, 32'h0, 32'h0, 32'h33); step();
    check("ww_pulse", pulse2, 0);
    set2(0, 5'd7, 5'd3, 5'd3, 32'h33, 32'h0, 32'h0);
    set2(1, 5'd3, 5'd7, 5'd3, 32'h0, 32'h22, 32'h0); step();
    check("ww_pulse2", pulse2, 1);
    check("ww_chan", chan2, 1);
    check("ww_kind", kind2, 1);
    check("ww_expected", exp2, 32'h33);
    check("ww_count", cnt2, 4);

    // own write invisible to own read; ch0 error beats ch1 error
    set2(0, 5'd10, 5'd3, 5'd10, 32'h5, 32'h0, 32'h5);
    set2(1, 5'd10, 5'd3, 5'd3, 32'h6, 32'h0, 32'h0); step();
    check("own_chan", chan2, 0);
    check("own_reg", reg2, 10);
    check("own_expected", exp2, 0);
    check("own_actual", act2, 32'h5);
    check("own_count", cnt2, 6);

    // rd=0 with a nonzero value, then read x0 (entry 1 tracks index 0)
    set2(0, 5'd3, 5'd3, 5'd0, 32'h0, 32'h0, 32'h5); step();
`ifdef RVFI_REGFILE_CHECK_X0_EN
    check("x0_pulse", pulse2, 1);
    check("x0_kind", kind2, 2);
    check("x0_reg", reg2, 0);
    check("x0_expected", exp2, 0);
    check("x0_actual", act2, 32'h5);
    set2(0, 5'd0, 5'd3, 5'd3, 32'h0, 32'h0, 32'h0); step();
`else
    check("x0_pulse", pulse2, 0);
    set2(0, 5'd0, 5'd3, 5'd3, 32'h5, 32'h0, 32'h0); step();
`endif
    check("x0_rd_pulse", pulse2, 0);
    check("x0_rd_count", cnt2, 7);

    // mid-run reset with a retirement in flight; entry 0 now tracks x9
    track1 = {5'd8, 5'd7, 5'd6, 5'd9};
    reset = 1'b1;
    set1(5'd5, 5'd5, 5'd9, 32'h7, 32'h7, 32'h77); step();
    reset = 1'b0;
    check("mrst_pulse", pulse1, 0);
    check("mrst_sticky", sticky1, 0);
    check("mrst_kind", kind1, 0);
    check("mrst_reg", reg1, 0);
    check("mrst_actual", act1, 0);
    check("mrst_count", cnt1, 0);
    check("mrst_sticky2", sticky2, 0);
    check("mrst_count2", cnt2, 0);

    set1(5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h1); step();
    set1(5'd5, 5'd0, 5'd9, 32'h2, 32'h0, 32'hAA); step();
    check("untracked_pulse", pulse1, 0);
    check("untracked_count", cnt1, 0);
    set1(5'd9, 5'd0, 5'd0, 32'hAB, 32'h0, 32'h0); step();
    check("reload_pulse", pulse1, 1);
    check("reload_reg", reg1, 9);
    check("reload_expected", exp1, 32'hAA);
    check("reload_actual", act1, 32'hAB);
    check("reload_count", cnt1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
